// File: rtl/board_pkg.sv
// Shared board constants, motion FSM state type and per-player sprite offsets.
package board_pkg;

    localparam int NUM_TILES  = 20;
    localparam int BOARD_SIDE = 6;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        DONE
    } motion_state_t;

    // Sprite top-left offset inside a tile, so both players fit side by side.
    localparam logic [9:0] P0_OFF_X = 10'd0;
    localparam logic [9:0] P0_OFF_Y = 10'd8;
    localparam logic [9:0] P1_OFF_X = 10'd16;
    localparam logic [9:0] P1_OFF_Y = 10'd8;

    // Largest hop count a single command may request; larger values clamp here.
    localparam logic [2:0] MAX_STEPS = 3'd6;

    // Successor tile on the loop, wrapping from the last tile back to tile 0.
    function automatic logic [4:0] next_tile(input logic [4:0] t);
        return (t == 5'(NUM_TILES - 1)) ? 5'd0 : t + 5'd1;
    endfunction

endpackage

// File: rtl/tile_pos_lut.sv
// Combinational map from a loop tile index to the pixel position of its top-left corner.
module tile_pos_lut
    import board_pkg::*;
#(
    parameter int ORIGIN_X   = 160,
    parameter int ORIGIN_Y   = 80,
    parameter int TILE_PITCH = 32
) (
    input  logic [4:0] tile,
    output logic [9:0] px,
    output logic [9:0] py
);

    localparam int SEG = BOARD_SIDE - 1;

    logic [2:0] cx;
    logic [2:0] cy;
    int         t;

    // Walk the four sides: top left-to-right, right downwards, bottom leftwards, left upwards.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cx = '0;
        cy = '0;
        t  = int'(tile);
        if (t <= SEG) begin
            cx = 3'(t);
        end else if (t <= 2 * SEG) begin
            cx = 3'(SEG);
            cy = 3'(t - SEG);
        end else if (t <= 3 * SEG) begin
            cx = 3'(3 * SEG - t);
            cy = 3'(SEG);
        end else if (t < NUM_TILES) begin
            cy = 3'(NUM_TILES - t);
        end
    end

    assign px = 10'(ORIGIN_X + int'(cx) * TILE_PITCH);
    assign py = 10'(ORIGIN_Y + int'(cy) * TILE_PITCH);

endmodule

// File: rtl/player_motion_ctrl.sv
// Moves one of two players tile by tile around the board loop, animating a
// frame-paced hop per step, and drives both sprite positions and draw order.
module player_motion_ctrl
    import board_pkg::*;
#(
    parameter int ORIGIN_X    = 160,
    parameter int ORIGIN_Y    = 80,
    parameter int TILE_PITCH  = 32,
    parameter int LOG2_FRAMES = 3,
    parameter int HOP_STEP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic       move_player,
    input  logic [2:0] move_steps,
    output logic [9:0] p0_x,
    output logic [9:0] p0_y,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y,
    output logic [4:0] p0_tile,
    output logic [4:0] p1_tile,
    output logic       front_id,
    output logic       busy,
    output logic       move_done,
    output logic       lap_pulse
);

    localparam int FRAMES = 2 ** LOG2_FRAMES;

    localparam logic [9:0] P0_RST_X = 10'(ORIGIN_X) + P0_OFF_X;
    localparam logic [9:0] P0_RST_Y = 10'(ORIGIN_Y) + P0_OFF_Y;
    localparam logic [9:0] P1_RST_X = 10'(ORIGIN_X) + P1_OFF_X;
    localparam logic [9:0] P1_RST_Y = 10'(ORIGIN_Y) + P1_OFF_Y;

    motion_state_t          state;
    logic                   mover;
    logic [2:0]             steps_left;
    logic [LOG2_FRAMES-1:0] frame_cnt;
    logic [4:0]             tile [2];

    logic [2:0] steps_clamped;
    logic [4:0] cur_tile;
    logic [4:0] nxt_tile;
    logic [9:0] cur_px, cur_py, nxt_px, nxt_py;

    assign steps_clamped = (move_steps > MAX_STEPS) ? MAX_STEPS : move_steps;
    assign cur_tile      = tile[mover];
    assign nxt_tile      = next_tile(cur_tile);

    assign move_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign p0_tile    = tile[0];
    assign p1_tile    = tile[1];

    tile_pos_lut #(
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .TILE_PITCH(TILE_PITCH)
    ) u_cur_lut (
        .tile(cur_tile),
        .px  (cur_px),
        .py  (cur_py)
    );

    tile_pos_lut #(
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .TILE_PITCH(TILE_PITCH)
    ) u_nxt_lut (
        .tile(nxt_tile),
        .px  (nxt_px),
        .py  (nxt_py)
    );

    // Motion sequencer: accept a command, count frames per hop, advance the tile, report completion.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            mover      <= 1'b0;
            steps_left <= '0;
            frame_cnt  <= '0;
            // NOTE: the two-entry tile array is plain flops (not a RAM), so resetting it is fine.
            tile[0]    <= '0;
            tile[1]    <= '0;
            front_id   <= 1'b0;
            move_done  <= 1'b0;
            lap_pulse  <= 1'b0;
        end else begin
            move_done <= 1'b0;
            lap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        mover      <= move_player;
                        front_id   <= move_player;
                        steps_left <= steps_clamped;
                        frame_cnt  <= '0;
                        if (steps_clamped == 3'd0) begin
                            state     <= DONE;
                            move_done <= 1'b1;
                        end else begin
                            state <= HOP;
                        end
                    end
                end
                HOP: begin
                    if (frame_tick) begin
                        if (frame_cnt == '1) begin
                            frame_cnt   <= '0;
                            tile[mover] <= nxt_tile;
                            steps_left  <= steps_left - 3'd1;
                            lap_pulse   <= (nxt_tile == 5'd0);
                            if (steps_left == 3'd1) begin
                                state     <= DONE;
                                move_done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + LOG2_FRAMES'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [LOG2_FRAMES-1:0] k;
    logic signed [10:0]     k_s, dx, dy, ix, iy;
    logic [9:0]             hop, off_x, off_y, mov_x, mov_y;

    // Mover sprite position: linear step toward the next tile, lifted by a triangular hop.
    always_comb begin
        k   = (state == HOP) ? frame_cnt : '0;
        k_s = $signed({{(11 - LOG2_FRAMES){1'b0}}, k});
        dx  = $signed({1'b0, nxt_px}) - $signed({1'b0, cur_px});
        dy  = $signed({1'b0, nxt_py}) - $signed({1'b0, cur_py});
        ix  = $signed({1'b0, cur_px}) + ((dx * k_s) >>> LOG2_FRAMES);
        iy  = $signed({1'b0, cur_py}) + ((dy * k_s) >>> LOG2_FRAMES);
        if (int'(k) < FRAMES / 2) begin
            hop = 10'(int'(k) * HOP_STEP);
        end else begin
            hop = 10'((FRAMES - int'(k)) * HOP_STEP);
        end
        off_x = mover ? P1_OFF_X : P0_OFF_X;
        off_y = mover ? P1_OFF_Y : P0_OFF_Y;
        mov_x = 10'(ix) + off_x;
        mov_y = 10'(iy) - hop + off_y;
    end

    // Registered sprite positions; only the mover's register changes, the other keeps its tile spot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_x <= P0_RST_X;
            p0_y <= P0_RST_Y;
            p1_x <= P1_RST_X;
            p1_y <= P1_RST_Y;
        end else if (!mover) begin
            p0_x <= mov_x;
            p0_y <= mov_y;
        end else begin
            p1_x <= mov_x;
            p1_y <= mov_y;
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: reference model of the board
// loop, hand-checked hop trajectory, vector table, corner sequences, random moves.
module tb_player_motion_ctrl;

    localparam int F     = 8;
    localparam int PITCH = 32;
    localparam int OX    = 160;
    localparam int OY    = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic       move_player = 1'b0;
    logic [2:0] move_steps = 3'd0;
    logic [9:0] p0_x, p0_y, p1_x, p1_y;
    logic [4:0] p0_tile, p1_tile;
    logic       front_id, busy, move_done, lap_pulse;

    player_motion_ctrl #(
        .ORIGIN_X   (OX),
        .ORIGIN_Y   (OY),
        .TILE_PITCH (PITCH),
        .LOG2_FRAMES(3),
        .HOP_STEP   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_player(move_player),
        .move_steps (move_steps),
        .p0_x       (p0_x),
        .p0_y       (p0_y),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p0_tile    (p0_tile),
        .p1_tile    (p1_tile),
        .front_id   (front_id),
        .busy       (busy),
        .move_done  (move_done),
        .lap_pulse  (lap_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_tile[2];
    int lap_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (lap_pulse === 1'b1) lap_cnt++;
        if (move_done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tile coordinate by walking the perimeter: 5 right, 5 down, 5 left, 5 up.
    function automatic void coord(input int t, output int cx, output int cy);
        cx = 0;
        cy = 0;
        for (int i = 0; i < t; i++) begin
            case (i / 5)
                0:       cx++;
                1:       cy++;
                2:       cx--;
                default: cy--;
            endcase
        end
    endfunction

    function automatic int hop_h(input int k);
        return (k < F / 2) ? 2 * k : 2 * (F - k);
    endfunction

    function automatic int exp_x(input int p, input int t, input int k);
        int cx, cy, nx, ny;
        coord(t, cx, cy);
        coord((t + 1) % 20, nx, ny);
        return OX + cx * PITCH + ((nx - cx) * PITCH * k) / F + (p != 0 ? 16 : 0);
    endfunction

    function automatic int exp_y(input int p, input int t, input int k);
        int cx, cy, nx, ny;
        coord(t, cx, cy);
        coord((t + 1) % 20, nx, ny);
        return OY + cy * PITCH + ((ny - cy) * PITCH * k) / F + 8 - hop_h(k) + (p != 0 ? 0 : 0);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int mover, input int k);
        check({tag, " p0_x"}, p0_x, exp_x(0, m_tile[0], mover == 0 ? k : 0));
        check({tag, " p0_y"}, p0_y, exp_y(0, m_tile[0], mover == 0 ? k : 0));
        check({tag, " p1_x"}, p1_x, exp_x(1, m_tile[1], mover == 1 ? k : 0));
        check({tag, " p1_y"}, p1_y, exp_y(1, m_tile[1], mover == 1 ? k : 0));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (move_ready !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) check("ready_timeout", move_ready, 1);
    endtask

    task automatic accept(input int p, input int s, input bit tick_too);
        wait_ready();
        move_player = p[0];
        move_steps  = s[2:0];
        move_valid  = 1'b1;
        frame_tick  = tick_too;
        cyc(1);
        move_valid  = 1'b0;
        frame_tick  = 1'b0;
    endtask

    task automatic run_move(input int p, input int s, input bit tick_too);
        int eff;
        eff = (s > 6) ? 6 : s;
        accept(p, s, tick_too);
        check("busy_after_accept", busy, 1);
        check("front_id", front_id, p);
        check("done_at_accept", move_done, eff == 0);
        if (eff == 0) begin
            cyc(1);
            check("ready_after_zero", move_ready, 1);
            check("done_cleared", move_done, 0);
            check_pos("zero_move", p, 0);
            return;
        end
        cyc(1);
        check_pos("k0", p, 0);
        for (int j = 1; j <= eff * F; j++) begin
            tick();
            if (j % F == 0) m_tile[p] = (m_tile[p] + 1) % 20;
            check("p0_tile", p0_tile, m_tile[0]);
            check("p1_tile", p1_tile, m_tile[1]);
            check("lap_pulse", lap_pulse, (j % F == 0) && (m_tile[p] == 0));
            check("move_done", move_done, j == eff * F);
            cyc(1);
            check_pos("hop", p, j % F);
        end
        check("ready_end", move_ready, 1);
        check("busy_end", busy, 0);
    endtask

    typedef struct {
        int player;
        int steps;
        int exp_t0;
        int exp_t1;
        int exp_x;
        int exp_y;
        int exp_laps;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hx[8];
        int hy[8];
        int l0, d0;
        hx = '{160, 164, 168, 172, 176, 180, 184, 188};
        hy = '{88, 86, 84, 82, 80, 82, 84, 86};
        vecs[0] = '{1, 7, 1, 6,  336, 120, 0};
        vecs[1] = '{1, 6, 1, 12, 272, 248, 0};
        vecs[2] = '{1, 6, 1, 18, 176, 152, 0};
        vecs[3] = '{1, 3, 1, 1,  208, 88,  1};
        vecs[4] = '{0, 4, 5, 1,  320, 88,  0};
        vecs[5] = '{0, 1, 6, 1,  320, 120, 0};
        vecs[6] = '{0, 0, 6, 1,  320, 120, 0};
        m_tile[0] = 0;
        m_tile[1] = 0;

        // Reset state
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        check("rst p0_x", p0_x, 160);
        check("rst p0_y", p0_y, 88);
        check("rst p1_x", p1_x, 176);
        check("rst p1_y", p1_y, 88);
        check("rst p0_tile", p0_tile, 0);
        check("rst p1_tile", p1_tile, 0);
        check("rst move_ready", move_ready, 1);
        check("rst busy", busy, 0);
        check("rst front_id", front_id, 0);
        check("rst pulses", lap_cnt + done_cnt, 0);

        // One-step hop of P0 against literal trajectory
        d0 = done_cnt;
        accept(0, 1, 1'b0);
        cyc(1);
        check("hop1 x k0", p0_x, hx[0]);
        check("hop1 y k0", p0_y, hy[0]);
        for (int k = 1; k < F; k++) begin
            tick();
            cyc(1);
            check($sformatf("hop1 x k%0d", k), p0_x, hx[k]);
            check($sformatf("hop1 y k%0d", k), p0_y, hy[k]);
        end
        tick();
        check("hop1 done", move_done, 1);
        check("hop1 tile", p0_tile, 1);
        cyc(1);
        check("hop1 final x", p0_x, 192);
        check("hop1 final y", p0_y, 88);
        check("hop1 done count", done_cnt - d0, 1);
        m_tile[0] = 1;

        // Vector table: clamp, lap, corner, zero-step
        for (int v = 0; v < 7; v++) begin
            l0 = lap_cnt;
            run_move(vecs[v].player, vecs[v].steps, 1'b0);
            check($sformatf("vec%0d t0", v), p0_tile, vecs[v].exp_t0);
            check($sformatf("vec%0d t1", v), p1_tile, vecs[v].exp_t1);
            check($sformatf("vec%0d x", v), vecs[v].player != 0 ? int'(p1_x) : int'(p0_x), vecs[v].exp_x);
            check($sformatf("vec%0d y", v), vecs[v].player != 0 ? int'(p1_y) : int'(p0_y), vecs[v].exp_y);
            check($sformatf("vec%0d laps", v), lap_cnt - l0, vecs[v].exp_laps);
        end

        // Ticks while idle change nothing; tick on the accept cycle is not counted
        repeat (3) begin
            tick();
            cyc(1);
        end
        check("idle tick busy", busy, 0);
        check("idle tick t0", p0_tile, m_tile[0]);
        check_pos("idle tick", 0, 0);
        run_move(1, 1, 1'b1);

        // Command held during a move is ignored
        accept(1, 1, 1'b0);
        move_player = 1'b0;
        move_steps  = 3'd3;
        move_valid  = 1'b1;
        cyc(3);
        check("ignore busy", busy, 1);
        check("ignore front_id", front_id, 1);
        move_valid = 1'b0;
        for (int j = 0; j < F; j++) tick();
        m_tile[1] = (m_tile[1] + 1) % 20;
        check("ignore t1", p1_tile, m_tile[1]);
        cyc(1);
        check("ignore t0", p0_tile, m_tile[0]);
        check("ignore ready", move_ready, 1);
        check_pos("ignore", 1, 0);

        // Reset in frame 3 of step 2
        d0 = done_cnt;
        accept(0, 3, 1'b0);
        for (int j = 0; j < F + 3; j++) tick();
        rst_n = 1'b0;
        cyc(1);
        check("midrst busy", busy, 0);
        check("midrst p0_x", p0_x, 160);
        check("midrst p0_y", p0_y, 88);
        check("midrst p1_x", p1_x, 176);
        check("midrst p1_y", p1_y, 88);
        check("midrst t0", p0_tile, 0);
        check("midrst t1", p1_tile, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        check("midrst no done", done_cnt - d0, 0);
        check("midrst ready", move_ready, 1);
        m_tile[0] = 0;
        m_tile[1] = 0;

        // Randomized moves against the model
        for (int r = 0; r < 15; r++) begin
            run_move(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cyc(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Sequencer that moves the two board players tile by tile along a 20-tile rectangular loop and drives the `player_x`/`player_y`/`player_id` inputs of the two sprite renderer instances. It accepts a move command, which carries a player and a step count from the dice/turn logic. It animates one hop per step, paced by the VGA frame tick, and reports completion. It also arbitrates draw order so the most recently moved player is rendered on top.

## Interface
Parameters:
- `ORIGIN_X` (160): pixel x of tile 0 top-left.
- `ORIGIN_Y` (80): pixel y of tile 0 top-left.
- `TILE_PITCH` (32): tile spacing in pixels. Must be a multiple of `FRAMES_PER_STEP`.
- `LOG2_FRAMES` (3): `FRAMES_PER_STEP = 2**LOG2_FRAMES` frames per hop.
- `HOP_STEP` (2): hop height increment, in pixels per frame.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  synchronous active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame, from VGA timing.
- `move_valid`  in  1  move command valid.
- `move_ready`  out  1  controller can accept a command.
- `move_player`  in  1  0 = player 1 (Blue Bandana), 1 = player 2 (Christmas).
- `move_steps`  in  3  step count 0..6; 7 is clamped to 6.
- `p0_x`, `p0_y`, `p1_x`, `p1_y`  out  10 each  sprite top-left for each player.
- `p0_tile`, `p1_tile`  out  5 each  current tile index, 0..19.
- `front_id`  out  1  player to composite on top.
- `busy`  out  1  a move is in progress.
- `move_done`  out  1  one-cycle pulse when a move finishes.
- `lap_pulse`  out  1  one-cycle pulse when the moving player lands on tile 0.

## Operation
- **Tile map.** Side length 6, 20 tiles. Each tile has a coordinate `(cx,cy)` in tile units:
  - tiles 0..5: `(i, 0)`.
  - tiles 6..10: `(5, i-5)`.
  - tiles 11..15: `(15-i, 5)`.
  - tiles 16..19: `(0, 20-i)`.
  - Tile pixel position = `ORIGIN + c*TILE_PITCH`.
- **Sprite position.** Sprite = tile pixel + per-player offset. Player 0 offset is (+0, +8). Player 1 offset is (+16, +8).
- **States.**
  - `IDLE`: `move_ready=1`.
  - `HOP`: animating one step.
  - `DONE`: one cycle, `move_done=1`.
- **Accept.** On `move_valid && move_ready`:
  - Latch the player and the clamped step count.
  - Set `front_id <= move_player`.
  - Set `frame_cnt <= 0`.
  - If steps == 0, go to `DONE`; otherwise go to `HOP`.
- **HOP.** Each `frame_tick` increments `frame_cnt`. On the tick where `frame_cnt == F-1`:
  - `tile <= (tile+1) mod 20`.
  - `steps_left--` and `frame_cnt <= 0`.
  - If the new tile is 0, pulse `lap_pulse` in the same cycle as the tile update.
  - If `steps_left` was 1, go to `DONE`; otherwise stay in `HOP`.
- **Interpolation** for the moving player at frame `k`:
  - `x = x_cur + (dx*k) >> LOG2_FRAMES`, where `dx` ∈ {−PITCH, 0, +PITCH}. Use 11-bit signed arithmetic and truncate to 10 bits.
  - Same rule for `y`. Then subtract hop height.
  - Hop height: `k*HOP_STEP` for `k < F/2`, else `(F-k)*HOP_STEP`.
  - A non-moving player sits at its tile position.
- **Ignored inputs.**
  - `frame_tick` has no effect outside `HOP`.
  - `move_valid` while not ready is ignored and not queued; the requester holds it.
- **Flags.**
  - `busy` = state ≠ `IDLE`.
  - `move_ready` = state == `IDLE`.

## Timing
- **Reset values.**
  - State `IDLE`, so `move_ready=1` and `busy=0`.
  - Both tiles 0, `frame_cnt=0`, `front_id=0`, `move_done=0`, `lap_pulse=0`.
  - `p0=(160,88)`, `p1=(176,88)` with default parameters.
- **Reset mid-move.** Aborts the move. Both players return to tile 0 with no `move_done`.
- **Position latency.** Position outputs are registered, with 1-cycle latency after any tile, `frame_cnt` or state change.
- **Accept latency.** Accept cycle N → `busy=1` at N+1.
  - steps=0: `move_done` at N+1, `move_ready` at N+2.
- **Move length.** A move of S steps completes after exactly S×F `frame_tick`s. `move_done` is asserted the cycle after the final tick, and `move_ready` the cycle after that.
- **Simultaneous events.** A `frame_tick` coinciding with accept is not counted.

## Structure
- **Shared package `board_pkg`:**
  - `NUM_TILES=20`, `BOARD_SIDE=6`.
  - state enum `motion_state_t {IDLE, HOP, DONE}`.
  - player offset constants.
- **Sub-module `tile_pos_lut`:** combinational, tile index → `(px,py)` pixel, parameterized by `ORIGIN_*` and `TILE_PITCH`. Instantiate it twice: current tile and next tile of the mover.
- **Top module:** FSM, counters, interpolation, output registers.

## Test plan
- **Reset.** Deassert `rst_n`, then idle 10 cycles → `p0=(160,88)`, `p1=(176,88)`, tiles 0/0, `move_ready=1`, no pulses.
- **One-step hop.** Move P0 by 1, then issue ticks → `p0_x` follows 160,164,…,188; `p0_y` = 88,86,84,82,80,82,84,86. After tick 8: `p0=(192,88)`, `p0_tile=1`, `move_done` one pulse.
- **Lap.** Place P1 at tile 18 (via moves), then move 3 → tiles 19,0,1. A single `lap_pulse` fires when tile 0 is reached; final `p1=(208,88)`.
- **Corner.** Move P0 from tile 5 by 1 → x constant 320, y interpolates 88→120, with hop subtracted.
- **Handshake edge cases.**
  - `move_steps=0` → `move_done` at N+1, no motion.
  - `move_steps=7` → behaves as 6.
  - `move_valid` during `busy` is ignored.
  - `front_id` follows the last accepted player.
- **Reset mid-hop.** Assert `rst_n=0` at frame 3 of step 2 → next cycle both players at tile 0 positions, `busy=0`, no `move_done`.
